// File: rtl/ctrl_pipe.sv
// ctrl_pipe: per-stage control pipeline with stall, flush and bubble insertion.
// Define CTRL_PIPE_MC_EN to build the EX multi-cycle hold counter.
module ctrl_pipe #(
    parameter int W         = 17,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        ctrl_d,
    input  logic                valid_d,
    input  logic                mc_d,
    input  logic [STAGES-1:0]   stall_i,
    input  logic [STAGES-1:0]   flush_i,
    output logic [STAGES*W-1:0] ctrl_q,
    output logic [STAGES-1:0]   valid_q,
    output logic                stall_o,
    output logic                mc_busy
);

    localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

    logic [STAGES:0] hold;

    always_comb begin
        hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hold[k] = stall_i[k] | hold[k+1];
        end
        hold[0] = hold[0] | mc_busy;
    end

    assign stall_o = hold[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] src_ctrl;
        logic         src_valid;
        logic         bubble;
        logic [W-1:0] ctrl_r;
        logic         valid_r;

        if (k == 0) begin : g_first
            assign src_ctrl  = ctrl_d;
            assign src_valid = valid_d;
            assign bubble    = 1'b0;
        end else begin : g_rest
            assign src_ctrl  = ctrl_q[(k-1)*W +: W];
            assign src_valid = valid_q[k-1];
            assign bubble    = hold[k-1];
        end

        // flush > hold > bubble > load
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ctrl_r  <= '0;
                valid_r <= 1'b0;
            end else if (flush_i[k]) begin
                ctrl_r  <= '0;
                valid_r <= 1'b0;
            end else if (hold[k]) begin
                ctrl_r  <= ctrl_r;
                valid_r <= valid_r;
            end else if (bubble) begin
                ctrl_r  <= '0;
                valid_r <= 1'b0;
            end else begin
                ctrl_r  <= src_ctrl;
                valid_r <= src_valid;
            end
        end

        assign ctrl_q[k*W +: W] = ctrl_r;
        assign valid_q[k]       = valid_r;
    end

`ifdef CTRL_PIPE_MC_EN
    logic [CW-1:0] mc_cnt;

    // Count runs through external stalls; only a flush cuts it short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_cnt <= '0;
        end else if (flush_i[0]) begin
            mc_cnt <= '0;
        end else if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - CW'(1);
        end else if (!hold[0] && valid_d && mc_d) begin
            mc_cnt <= CW'(MC_CYCLES - 1);
        end
    end

    assign mc_busy = |mc_cnt;
`else
    logic unused_mc;
    assign unused_mc = mc_d;
    assign mc_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (W=17, STAGES=3, MC_CYCLES=4).
module tb_ctrl_pipe;

    localparam logic [16:0] A = 17'h1A5A5;
    localparam logic [16:0] B = 17'h00F0F;
    localparam logic [16:0] C = 17'h12345;
    localparam logic [16:0] D = 17'h0ABCD;
    localparam logic [16:0] E = 17'h15555;
    localparam logic [16:0] F = 17'h0F00D;
    localparam logic [16:0] M = 17'h1CAFE;
    localparam logic [16:0] N = 17'h0BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] ctrl_d;
    logic        valid_d;
    logic        mc_d;
    logic [2:0]  stall_i;
    logic [2:0]  flush_i;
    logic [50:0] ctrl_q;
    logic [2:0]  valid_q;
    logic        stall_o;
    logic        mc_busy;

    int errors = 0;
    int checks = 0;

    ctrl_pipe #(.W(17), .STAGES(3), .MC_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_d  (ctrl_d),
        .valid_d (valid_d),
        .mc_d    (mc_d),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .ctrl_q  (ctrl_q),
        .valid_q (valid_q),
        .stall_o (stall_o),
        .mc_busy (mc_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] stg(int k);
        return ctrl_q[k*17 +: 17];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        valid_d = 1'b0;
        mc_d    = 1'b0;
        ctrl_d  = '0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (valid_q !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: got %b want 000", valid_q);
        end
        checks++;
        if (ctrl_q !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 0", ctrl_q);
        end
        checks++;
        if (mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", mc_busy);
        end
        stall_i = 3'b100;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_o_hi: got %b want 1", stall_o);
        end
        stall_i = 3'b000;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_o_lo: got %b want 0", stall_o);
        end
        ctrl_d  = 17'h1FFFF;
        valid_d = 1'b1;
        mc_d    = 1'b1;
        step();
        checks++;
        if (valid_q !== 3'b000 || ctrl_q !== '0 || mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got v=%b c=%h b=%b want 000/0/0",
                     valid_q, ctrl_q, mc_busy);
        end
        rst     = 1'b1;
        ctrl_d  = '0;
        valid_d = 1'b0;
        mc_d    = 1'b0;
        step();
    endtask

    task automatic test_flow();
        ctrl_d  = A;
        valid_d = 1'b1;
        step();
        checks++;
        if (valid_q !== 3'b001 || stg(0) !== A) begin
            errors++;
            $display("FAIL flow_e1: got v=%b s0=%h want 001/%h",
                     valid_q, stg(0), A);
        end
        ctrl_d = B;
        step();
        checks++;
        if (valid_q !== 3'b011 || stg(1) !== A || stg(0) !== B) begin
            errors++;
            $display("FAIL flow_e2: got v=%b s1=%h s0=%h want 011/%h/%h",
                     valid_q, stg(1), stg(0), A, B);
        end
        ctrl_d = C;
        step();
        checks++;
        if (valid_q !== 3'b111 || stg(2) !== A || stg(1) !== B
            || stg(0) !== C) begin
            errors++;
            $display("FAIL flow_e3: got v=%b s=%h want 111/%h,%h,%h",
                     valid_q, ctrl_q, C, B, A);
        end
    endtask

    task automatic test_stall_bubble();
        ctrl_d  = D;
        stall_i = 3'b010;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_o: got %b want 1", stall_o);
        end
        step();
        checks++;
        if (valid_q !== 3'b011 || stg(2) !== '0 || stg(1) !== B
            || stg(0) !== C) begin
            errors++;
            $display("FAIL stall_bubble: got v=%b s=%h want 011 s2=0 s1=%h s0=%h",
                     valid_q, ctrl_q, B, C);
        end
        stall_i = 3'b000;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_o_release: got %b want 0", stall_o);
        end
        step();
        checks++;
        if (valid_q !== 3'b111 || stg(0) !== D || stg(1) !== C
            || stg(2) !== B) begin
            errors++;
            $display("FAIL stall_resume: got v=%b s=%h want 111/%h,%h,%h",
                     valid_q, ctrl_q, D, C, B);
        end
    endtask

    task automatic test_flush();
        ctrl_d  = E;
        flush_i = 3'b001;
        stall_i = 3'b001;
        step();
        checks++;
        if (valid_q !== 3'b100 || stg(0) !== '0 || stg(1) !== '0
            || stg(2) !== C) begin
            errors++;
            $display("FAIL flush_prio: got v=%b s=%h want 100 s2=%h",
                     valid_q, ctrl_q, C);
        end
        flush_i = 3'b000;
        stall_i = 3'b000;
        step();
        checks++;
        if (valid_q !== 3'b001 || stg(0) !== E || stg(1) !== '0) begin
            errors++;
            $display("FAIL flush_bubble_fwd: got v=%b s=%h want 001 s0=%h s1=0",
                     valid_q, ctrl_q, E);
        end
        drain();
        checks++;
        if (valid_q !== 3'b000) begin
            errors++;
            $display("FAIL flush_drain: got %b want 000", valid_q);
        end
    endtask

    task automatic test_multicycle();
        ctrl_d  = M;
        valid_d = 1'b1;
        mc_d    = 1'b1;
        step();
        ctrl_d = N;
        mc_d   = 1'b0;
`ifdef CTRL_PIPE_MC_EN
        checks++;
        if (mc_busy !== 1'b1 || stall_o !== 1'b1 || stg(0) !== M) begin
            errors++;
            $display("FAIL mc_start: got b=%b so=%b s0=%h want 1/1/%h",
                     mc_busy, stall_o, stg(0), M);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (stg(0) !== M || valid_q[1] !== 1'b0
                || mc_busy !== (i < 3)) begin
                errors++;
                $display("FAIL mc_hold_%0d: got s0=%h v1=%b b=%b want %h/0/%b",
                         i, stg(0), valid_q[1], mc_busy, M, (i < 3));
            end
        end
        step();
        checks++;
        if (stg(1) !== M || valid_q[1] !== 1'b1 || stg(0) !== N) begin
            errors++;
            $display("FAIL mc_advance: got s1=%h v1=%b s0=%h want %h/1/%h",
                     stg(1), valid_q[1], stg(0), M, N);
        end
`else
        checks++;
        if (mc_busy !== 1'b0 || stall_o !== 1'b0 || stg(0) !== M) begin
            errors++;
            $display("FAIL mc_off_start: got b=%b so=%b s0=%h want 0/0/%h",
                     mc_busy, stall_o, stg(0), M);
        end
        step();
        checks++;
        if (stg(1) !== M || stg(0) !== N || mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL mc_off_advance: got s1=%h s0=%h b=%b want %h/%h/0",
                     stg(1), stg(0), mc_busy, M, N);
        end
`endif
        drain();
    endtask

    task automatic test_mc_flush();
        ctrl_d  = M;
        valid_d = 1'b1;
        mc_d    = 1'b1;
        flush_i = 3'b001;
        step();
        checks++;
        if (valid_q[0] !== 1'b0 || stg(0) !== '0 || mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL mc_load_flush: got v0=%b s0=%h b=%b want 0/0/0",
                     valid_q[0], stg(0), mc_busy);
        end
        flush_i = 3'b000;
        step();
        valid_d = 1'b0;
        mc_d    = 1'b0;
        ctrl_d  = '0;
`ifdef CTRL_PIPE_MC_EN
        step();
        checks++;
        if (mc_busy !== 1'b1 || stg(0) !== M) begin
            errors++;
            $display("FAIL mc_busy_2nd: got b=%b s0=%h want 1/%h",
                     mc_busy, stg(0), M);
        end
        flush_i = 3'b001;
        step();
        flush_i = 3'b000;
        checks++;
        if (mc_busy !== 1'b0 || stall_o !== 1'b0 || valid_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL mc_flush_end: got b=%b so=%b v0=%b want 0/0/0",
                     mc_busy, stall_o, valid_q[0]);
        end
`else
        checks++;
        if (mc_busy !== 1'b0 || valid_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL mc_off_load: got b=%b v0=%b want 0/1",
                     mc_busy, valid_q[0]);
        end
`endif
        drain();
    endtask

    task automatic test_reset_mid();
        ctrl_d  = A;
        valid_d = 1'b1;
        mc_d    = 1'b1;
        step();
        ctrl_d = B;
        mc_d   = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (valid_q !== 3'b000 || ctrl_q !== '0 || mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b c=%h b=%b want 000/0/0",
                     valid_q, ctrl_q, mc_busy);
        end
        #1;
        rst    = 1'b1;
        ctrl_d = F;
        step();
        checks++;
        if (valid_q !== 3'b001 || stg(0) !== F || mc_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got v=%b s0=%h b=%b want 001/%h/0",
                     valid_q, stg(0), mc_busy, F);
        end
    endtask

    initial begin
        rst     = 1'b0;
        ctrl_d  = '0;
        valid_d = 1'b0;
        mc_d    = 1'b0;
        stall_i = '0;
        flush_i = '0;
        test_reset();
        test_flow();
        test_stall_bubble();
        test_flush();
        test_multicycle();
        test_mc_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline carrying the decoded control bundle from ID through STAGES registered stages (EX, MEM, WB, … by default). Each stage has its own stall and flush, a valid bit, and automatic bubble insertion. An optional multi-cycle hold keeps the EX stage occupied for long-latency ops such as HI/LO multiply/divide. Sits between the main/ALU decoders and the datapath, where per-stage control flops were previously hand-instantiated.

## Interface

- `W`, default 17: control bundle width in bits.
- `STAGES`, default 3: number of registered stages; index 0 = EX, 1 = MEM, 2 = WB.
- `MC_CYCLES`, default 4: total EX occupancy in cycles for a multi-cycle op; must be ≥1.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ctrl_d` in W: control bundle from ID decode.
- `valid_d` in 1: the ID bundle is a real instruction.
- `mc_d` in 1: the ID bundle is a multi-cycle op.
- `stall_i` in STAGES: per-stage external stall; bit k = stage k.
- `flush_i` in STAGES: per-stage flush; bit k = stage k.
- `ctrl_q` out STAGES*W: stage k bundle at bits [k*W +: W].
- `valid_q` out STAGES: per-stage valid.
- `stall_o` out 1: ID must hold, because stage 0 is not accepting.
- `mc_busy` out 1: EX multi-cycle hold is active.

## Operation

- `hold[k] = stall_i[k] | hold[k+1]`, with `hold[STAGES] = 0`. Stage 0 additionally ORs in `mc_busy`.
- `stall_o = hold[0]`. This is combinational and has no register.
- Update priority per stage k, per clock:
  1. **Flush.** If `flush_i[k]`, set `valid_q[k]=0` and the stage bundle to 0.
  2. **Hold.** Else if `hold[k]`, keep the stage contents.
  3. **Bubble.** Else if k>0 and `hold[k-1]`, set valid=0 and bundle=0.
  4. **Load.** Otherwise load from the previous stage; stage 0 loads `ctrl_d`/`valid_d`.
- Flush beats hold: a flushed, stalled stage becomes a bubble.
- Multi-cycle counter `mc_cnt` has width `$clog2(MC_CYCLES)`, minimum 1.
  - When stage 0 loads with `valid_d & mc_d`, `mc_cnt` loads `MC_CYCLES-1`.
  - While `mc_cnt != 0` it decrements each cycle and `mc_busy=1`.
  - `flush_i[0]` clears `mc_cnt` immediately in the same edge, which ends the hold.
  - An external `stall_i[0]` while counting does not pause the count.
- `MC_CYCLES=1` never sets `mc_busy`.
- A bundle with `valid_d=0` never starts the counter, regardless of `mc_d`.
- Stages are plain registers; the block does no decoding. Bits that are unused in later stages are left for synthesis to prune.

## Timing

- Latency is 1 cycle per stage. ID→stage k takes k+1 edges when there is no hold.
- On `rst` low, asynchronously: all `valid_q` = 0, all `ctrl_q` = 0, `mc_cnt` = 0, `mc_busy` = 0. `stall_o` then follows `stall_i` combinationally.
- Reset deassertion mid-operation: the first edge after release is a normal load.
- Multi-cycle op loaded at edge t:
  - `mc_busy` is high after t for `MC_CYCLES-1` cycles.
  - Stage 0 and ID are held over that window.
  - The op advances to stage 1 at edge `t+MC_CYCLES`.
  - Stage 1 receives bubbles while stage 0 is held.
- A multi-cycle op arriving while `mc_cnt != 0` is impossible, because ID is held.
- Simultaneous `flush_i[0]` and a multi-cycle load: flush wins, and the counter stays 0.

## Configuration

- `CTRL_PIPE_MC_EN`:
  - **Defined:** the multi-cycle counter and `mc_busy` logic are compiled in as above.
  - **Undefined:** no counter is built, `mc_d` is ignored, `mc_busy` is tied 0, and stage 0's hold reduces to `stall_i[0] | hold[1]`.

## Test plan

- **Reset:** drive `rst`=0 mid-stream with valid bundles in flight -> `valid_q`=3'b000, `ctrl_q`=0 asynchronously (before the next edge), `mc_busy`=0.
- **Flow:** feed `ctrl_d`=17'h1A5A5, 17'h00F0F, 17'h12345 with `valid_d`=1 on consecutive cycles, no stalls -> 17'h1A5A5 appears in stage 0/1/2 on edges 1/2/3; `valid_q` goes 001, 011, 111.
- **Stall with bubble:** `stall_i`=3'b010 for one cycle with all stages full -> stages 0–1 hold, `stall_o`=1, stage 2 gets a bubble (`valid_q[2]`=0, bundle 0), and flow resumes the next cycle.
- **Flush priority:** `flush_i`=3'b001 and `stall_i`=3'b001 together -> stage 0 becomes valid=0 and bundle 0, and stage 1 receives that bubble on the next unstalled edge.
- **Multi-cycle:** with the macro defined and `MC_CYCLES`=4, load `valid_d`=1, `mc_d`=1 -> `mc_busy` and `stall_o` are high for 3 cycles, stage 1 sees 3 bubbles, and the op reaches stage 1 at edge 4. Flushing stage 0 in the 2nd busy cycle -> `mc_busy` drops after that edge.
- **Macro off:** without the macro, same stimulus -> `mc_busy`=0 throughout, and the op reaches stage 1 after 1 edge.
